// File: rtl/fpnew_divsqrt_multi_dispatch_if.sv
// Issue/retire handshake bundle between the FPU opgroup and the div/sqrt
// dispatcher.
interface fpnew_divsqrt_multi_dispatch_if #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned TagWidth = 4
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [TagWidth-1:0] in_tag_i;
  logic                in_mask_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [WIDTH-1:0]    result_o;
  logic [4:0]          status_o;
  logic [TagWidth-1:0] tag_o;
  logic                mask_o;

  modport master (
    output in_valid_i, in_tag_i, in_mask_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, status_o, tag_o, mask_o
  );

  modport slave (
    input  in_valid_i, in_tag_i, in_mask_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, status_o, tag_o, mask_o
  );
endinterface

// File: rtl/fpnew_divsqrt_multi_dispatch.sv
// Round-robin dispatcher over NumUnits iterative div/sqrt units, retiring in
// issue order. FPNEW_DIVSQRT_DISPATCH_BYPASS_EN enables same-cycle retire.
module fpnew_divsqrt_multi_dispatch #(
  parameter int unsigned NumUnits = 2,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned TagWidth = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  fpnew_divsqrt_multi_dispatch_if.slave      bus,
  output logic [NumUnits-1:0]                unit_start_o,
  input  logic [NumUnits-1:0]                unit_ready_i,
  input  logic [NumUnits-1:0]                unit_done_i,
  input  logic [NumUnits-1:0][WIDTH-1:0]     unit_result_i,
  input  logic [NumUnits-1:0][4:0]           unit_status_i,
  output logic                               unit_flush_o,
  input  logic                               flush_i,
  output logic                               busy_o,
  output logic                               err_spurious_o
);

  localparam int unsigned PtrW = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_e;

  slot_e               state_q [NumUnits];
  slot_e               state_d [NumUnits];
  logic [TagWidth-1:0] tag_q   [NumUnits];
  logic                mask_q  [NumUnits];
  logic [WIDTH-1:0]    res_q   [NumUnits];
  logic [4:0]          st_q    [NumUnits];

  ptr_t issue_q, issue_d;
  ptr_t ret_q, ret_d;
  logic spur_q, spur_d;

  logic in_ready, accept;
  logic out_valid, retire, byp;

  function automatic ptr_t wrap_inc(ptr_t p);
    return (p == ptr_t'(NumUnits - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    in_ready = (state_q[issue_q] == IDLE)
             & unit_ready_i[issue_q] & ~flush_i;
    accept   = bus.in_valid_i & in_ready;
    unit_start_o = '0;
    if (accept) unit_start_o[issue_q] = 1'b1;
`ifdef FPNEW_DIVSQRT_DISPATCH_BYPASS_EN
    byp = (state_q[ret_q] == BUSY)
        & unit_done_i[ret_q] & ~flush_i;
`else
    byp = 1'b0;
`endif
    out_valid = ~flush_i & ((state_q[ret_q] == DONE) | byp);
    retire    = out_valid & bus.out_ready_i;
  end

  always_comb begin
    bus.result_o = '0;
    bus.status_o = '0;
    bus.tag_o    = '0;
    bus.mask_o   = 1'b0;
    if (out_valid) begin
      bus.tag_o    = tag_q[ret_q];
      bus.mask_o   = mask_q[ret_q];
      bus.result_o = byp ? unit_result_i[ret_q] : res_q[ret_q];
      bus.status_o = byp ? unit_status_i[ret_q] : st_q[ret_q];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign unit_flush_o    = flush_i;
  assign err_spurious_o  = spur_q;

  always_comb begin
    issue_d = issue_q;
    ret_d   = ret_q;
    spur_d  = spur_q;
    busy_o  = 1'b0;
    for (int k = 0; k < NumUnits; k++) begin
      state_d[k] = state_q[k];
      busy_o     = busy_o | (state_q[k] != IDLE);
      if (unit_done_i[k] && !flush_i) begin
        if (state_q[k] == BUSY) state_d[k] = DONE;
        else                    spur_d     = 1'b1;
      end
      if (accept && issue_q == ptr_t'(k)) state_d[k] = BUSY;
      // a bypassed retire overrides the DONE set above
      if (retire && ret_q == ptr_t'(k)) state_d[k] = IDLE;
    end
    if (accept) issue_d = wrap_inc(issue_q);
    if (retire) ret_d   = wrap_inc(ret_q);
    if (flush_i) begin
      for (int k = 0; k < NumUnits; k++) state_d[k] = IDLE;
      issue_d = '0;
      ret_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumUnits; k++) state_q[k] <= IDLE;
      issue_q <= '0;
      ret_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NumUnits; k++) state_q[k] <= state_d[k];
      issue_q <= issue_d;
      ret_q   <= ret_d;
      spur_q  <= spur_d;
    end
  end

  // payload is only observed through a valid slot, so it needs no reset
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumUnits; k++) begin
      if (accept && issue_q == ptr_t'(k)) begin
        tag_q[k]  <= bus.in_tag_i;
        mask_q[k] <= bus.in_mask_i;
      end
      if (unit_done_i[k] && !flush_i && state_q[k] == BUSY) begin
        res_q[k] <= unit_result_i[k];
        st_q[k]  <= unit_status_i[k];
      end
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_multi_dispatch.sv
// Directed scoreboard bench for the div/sqrt dispatcher, NumUnits=2 and 3.
// Latency expectations follow FPNEW_DIVSQRT_DISPATCH_BYPASS_EN.
module tb_fpnew_divsqrt_multi_dispatch;

`ifdef FPNEW_DIVSQRT_DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  tag;
    logic        mask;
    logic [4:0]  st;
    logic [63:0] res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;
  int ret2   = 0;
  int ret3   = 0;
  exp_t q2[$];
  exp_t q3[$];

  fpnew_divsqrt_multi_dispatch_if #(.WIDTH(64), .TagWidth(4)) b2 ();
  fpnew_divsqrt_multi_dispatch_if #(.WIDTH(64), .TagWidth(4)) b3 ();

  logic [1:0]        start2, ready2, done2;
  logic [1:0][63:0]  result2;
  logic [1:0][4:0]   status2;
  logic              uflush2, flush2, busy2, err2;

  logic [2:0]        start3, ready3, done3;
  logic [2:0][63:0]  result3;
  logic [2:0][4:0]   status3;
  logic              uflush3, flush3, busy3, err3;

  fpnew_divsqrt_multi_dispatch #(.NumUnits(2), .WIDTH(64), .TagWidth(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b2),
    .unit_start_o(start2), .unit_ready_i(ready2), .unit_done_i(done2),
    .unit_result_i(result2), .unit_status_i(status2),
    .unit_flush_o(uflush2), .flush_i(flush2),
    .busy_o(busy2), .err_spurious_o(err2)
  );

  fpnew_divsqrt_multi_dispatch #(.NumUnits(3), .WIDTH(64), .TagWidth(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b3),
    .unit_start_o(start3), .unit_ready_i(ready3), .unit_done_i(done3),
    .unit_result_i(result3), .unit_status_i(status3),
    .unit_flush_o(uflush3), .flush_i(flush3),
    .busy_o(busy3), .err_spurious_o(err3)
  );

  function automatic logic [63:0] fres(logic [3:0] t);
    return 64'hA500_0000_0000_0000 | (64'(t) << 32) | 64'(t);
  endfunction

  function automatic logic [4:0] fst(logic [3:0] t);
    return {1'b1, t};
  endfunction

  function automatic exp_t mk(logic [3:0] t);
    exp_t e;
    e.tag  = t;
    e.mask = t[0];
    e.st   = fst(t);
    e.res  = fres(t);
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue2(logic [3:0] t);
    b2.in_valid_i = 1'b1;
    b2.in_tag_i   = t;
    b2.in_mask_i  = t[0];
    q2.push_back(mk(t));
  endtask

  task automatic issue3(logic [3:0] t);
    b3.in_valid_i = 1'b1;
    b3.in_tag_i   = t;
    b3.in_mask_i  = t[0];
    q3.push_back(mk(t));
  endtask

  task automatic fin2(int k, logic [3:0] t);
    done2[k]   = 1'b1;
    result2[k] = fres(t);
    status2[k] = fst(t);
  endtask

  task automatic fin3(int k, logic [3:0] t);
    done3[k]   = 1'b1;
    result3[k] = fres(t);
    status3[k] = fst(t);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b2.out_valid_o && b2.out_ready_i) begin
      chk("sb2_nonempty", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("sb2_tag", 64'(b2.tag_o), 64'(e.tag));
        chk("sb2_res", b2.result_o, e.res);
        chk("sb2_st", 64'(b2.status_o), 64'(e.st));
        chk("sb2_mask", 64'(b2.mask_o), 64'(e.mask));
        ret2++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b3.out_valid_o && b3.out_ready_i) begin
      chk("sb3_nonempty", 64'(q3.size() != 0), 64'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("sb3_tag", 64'(b3.tag_o), 64'(e.tag));
        chk("sb3_res", b3.result_o, e.res);
        chk("sb3_st", 64'(b3.status_o), 64'(e.st));
        chk("sb3_mask", 64'(b3.mask_o), 64'(e.mask));
        ret3++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    b2.in_valid_i = 1'b0; b2.in_tag_i = '0; b2.in_mask_i = 1'b0;
    b2.out_ready_i = 1'b0;
    b3.in_valid_i = 1'b0; b3.in_tag_i = '0; b3.in_mask_i = 1'b0;
    b3.out_ready_i = 1'b0;
    ready2 = '0; done2 = '0; result2 = '0; status2 = '0; flush2 = 1'b0;
    ready3 = '0; done3 = '0; result3 = '0; status3 = '0; flush3 = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_busy", 64'(busy2), 0);
    chk("rst_valid", 64'(b2.out_valid_o), 0);
    chk("rst_result", b2.result_o, 0);
    chk("rst_tag", 64'(b2.tag_o), 0);
    chk("rst_status", 64'(b2.status_o), 0);
    chk("rst_mask", 64'(b2.mask_o), 0);
    chk("rst_err", 64'(err2), 0);
    chk("rst_start", 64'(start2), 0);

    step(); rst_n = 1'b1; ready2 = 2'b10;
    @(negedge clk);
    chk("rdy_unit0_low", 64'(b2.in_ready_o), 0);
    step(); ready2 = 2'b11; b2.out_ready_i = 1'b1;
    @(negedge clk);
    chk("rdy_unit0_high", 64'(b2.in_ready_o), 1);

    // out-of-order completion, cycle 0 = first issue
    step(); issue2(4'd1);
    @(negedge clk); chk("t1_start_a", 64'(start2), 64'b01);
    step(); issue2(4'd2);
    @(negedge clk); chk("t1_start_b", 64'(start2), 64'b10);
    step(); b2.in_valid_i = 1'b0;
    @(negedge clk);
    chk("t1_full", 64'(b2.in_ready_o), 0);
    chk("t1_nostart", 64'(start2), 0);
    repeat (18) step();
    fin2(1, 4'd2);
    @(negedge clk); chk("t1_c20_valid", 64'(b2.out_valid_o), 0);
    step(); done2 = '0;
    @(negedge clk); chk("t1_c21_valid", 64'(b2.out_valid_o), 0);
    repeat (9) step();
    fin2(0, 4'd1);
    @(negedge clk); chk("t1_c30_valid", 64'(b2.out_valid_o), 64'(BYP));
    step(); done2 = '0;
    @(negedge clk);
    chk("t1_c31_valid", 64'(b2.out_valid_o), 1);
    chk("t1_c31_tag", 64'(b2.tag_o), BYP ? 64'd2 : 64'd1);
    step();
    @(negedge clk);
    chk("t1_c32_valid", 64'(b2.out_valid_o), BYP ? 64'd0 : 64'd1);
    chk("t1_c32_tag", 64'(b2.tag_o), BYP ? 64'd0 : 64'd2);
    step();
    @(negedge clk); chk("t1_idle", 64'(busy2), 0);

    // backpressure with both slots done
    step(); b2.out_ready_i = 1'b0; issue2(4'd3);
    step(); issue2(4'd4);
    step(); b2.in_valid_i = 1'b0; fin2(0, 4'd3); fin2(1, 4'd4);
    step(); done2 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(b2.out_valid_o), 1);
      chk("t2_hold_tag", 64'(b2.tag_o), 3);
      chk("t2_hold_res", b2.result_o, fres(4'd3));
      chk("t2_full", 64'(b2.in_ready_o), 0);
      step();
    end
    b2.out_ready_i = 1'b1;
    @(negedge clk); chk("t2_ret_a", 64'(b2.tag_o), 3);
    step();
    @(negedge clk); chk("t2_ret_b", 64'(b2.tag_o), 4);
    step();
    @(negedge clk);
    chk("t2_drained", 64'(b2.out_valid_o), 0);
    chk("t2_ready", 64'(b2.in_ready_o), 1);

    // flush with two ops in flight and pointers away from 0
    step(); issue2(4'd6);
    step(); b2.in_valid_i = 1'b0; fin2(0, 4'd6);
    step(); done2 = '0;
    step();
    @(negedge clk); chk("t3_pre_idle", 64'(busy2), 0);
    step(); issue2(4'd7);
    @(negedge clk); chk("t3_start_a", 64'(start2), 64'b10);
    step(); issue2(4'd8);
    @(negedge clk); chk("t3_start_b", 64'(start2), 64'b01);
    step();
    b2.in_tag_i = 4'd9; flush2 = 1'b1; fin2(0, 4'd8);
    q2.delete();
    @(negedge clk);
    chk("t3_fl_ready", 64'(b2.in_ready_o), 0);
    chk("t3_fl_start", 64'(start2), 0);
    chk("t3_fl_valid", 64'(b2.out_valid_o), 0);
    chk("t3_fl_unit", 64'(uflush2), 1);
    step(); flush2 = 1'b0; done2 = '0; b2.in_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_busy", 64'(busy2), 0);
    chk("t3_valid", 64'(b2.out_valid_o), 0);
    chk("t3_err", 64'(err2), 0);
    step(); issue2(4'd9);
    @(negedge clk); chk("t3_restart", 64'(start2), 64'b01);
    step(); b2.in_valid_i = 1'b0; fin2(0, 4'd9);
    step(); done2 = '0;
    step();
    @(negedge clk); chk("t3_done_idle", 64'(busy2), 0);

    // spurious done and mid-operation reset
    step(); fin2(1, 4'd15);
    @(negedge clk); chk("t5_sp_valid", 64'(b2.out_valid_o), 0);
    step(); done2 = '0;
    @(negedge clk);
    chk("t5_err", 64'(err2), 1);
    chk("t5_busy", 64'(busy2), 0);
    step(); issue2(4'd10);
    @(negedge clk); chk("t5_start", 64'(start2), 64'b10);
    step(); b2.in_valid_i = 1'b0; rst_n = 1'b0; q2.delete();
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_busy0", 64'(busy2), 0);
    chk("t5_err0", 64'(err2), 0);
    chk("t5_valid0", 64'(b2.out_valid_o), 0);
    chk("t5_res0", b2.result_o, 0);
    chk("t5_tag0", 64'(b2.tag_o), 0);
    chk("t5_ready", 64'(b2.in_ready_o), 1);
    step(); issue2(4'd11);
    @(negedge clk); chk("t5_restart", 64'(start2), 64'b01);
    step(); b2.in_valid_i = 1'b0; fin2(0, 4'd11);
    step(); done2 = '0;
    step();

    // done on the retire slot with consumer ready
    step();
    b2.in_valid_i = 1'b1; b2.in_tag_i = 4'd12; b2.in_mask_i = 1'b0;
    q2.push_back('{tag: 4'd12, mask: 1'b0, st: fst(4'd12),
                   res: 64'h3FF0_0000_0000_0000});
    @(negedge clk); chk("t6_start", 64'(start2), 64'b10);
    step(); b2.in_valid_i = 1'b0;
    done2[1] = 1'b1; result2[1] = 64'h3FF0_0000_0000_0000;
    status2[1] = fst(4'd12);
    @(negedge clk);
    chk("t6_valid", 64'(b2.out_valid_o), 64'(BYP));
    chk("t6_res", b2.result_o, BYP ? 64'h3FF0_0000_0000_0000 : 64'd0);
    step(); done2 = '0;
    @(negedge clk);
    chk("t6_busy", 64'(busy2), BYP ? 64'd0 : 64'd1);
    chk("t6_res_next", b2.result_o, BYP ? 64'd0 : 64'h3FF0_0000_0000_0000);
    step();
    @(negedge clk); chk("t6_idle", 64'(busy2), 0);

    // three-unit wrap
    step(); ready3 = 3'b111; b3.out_ready_i = 1'b0; issue3(4'd2);
    @(negedge clk); chk("t4_start_0", 64'(start3), 64'b001);
    step(); issue3(4'd3);
    @(negedge clk); chk("t4_start_1", 64'(start3), 64'b010);
    step(); issue3(4'd4);
    @(negedge clk); chk("t4_start_2", 64'(start3), 64'b100);
    step(); b3.in_tag_i = 4'd5; b3.in_mask_i = 1'b1;
    fin3(0, 4'd2); fin3(1, 4'd3); fin3(2, 4'd4);
    @(negedge clk);
    chk("t4_full", 64'(b3.in_ready_o), 0);
    chk("t4_full_start", 64'(start3), 0);
    step(); done3 = '0; b3.out_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_ret_tag", 64'(b3.tag_o), 2);
    chk("t4_ret_noiss", 64'(start3), 0);
    step(); q3.push_back(mk(4'd5));
    @(negedge clk);
    chk("t4_wrap_ready", 64'(b3.in_ready_o), 1);
    chk("t4_wrap_start", 64'(start3), 64'b001);
    step(); b3.in_valid_i = 1'b0;
    step(); fin3(0, 4'd5);
    @(negedge clk); chk("t4_last_valid", 64'(b3.out_valid_o), 64'(BYP));
    step(); done3 = '0;
    step(); step();
    @(negedge clk); chk("t4_idle", 64'(busy3), 0);

    step();
    @(negedge clk);
    chk("ret2_count", 64'(ret2), 8);
    chk("ret3_count", 64'(ret3), 4);
    chk("q2_empty", 64'(q2.size()), 0);
    chk("q3_empty", 64'(q3.size()), 0);
    chk("err3_clear", 64'(err3), 0);
    chk("uflush3_low", 64'(uflush3), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
